vga_sync_rx: RTL

Receive-side counterpart of `vga_sync`. It consumes the `h_sync`/`v_sync`/8-bit pixel stream that `vga_sync` produces and recovers pixel coordinates. It measures line and frame timing and declares lock once the timing matches 640x480@60. It sits in the VU-meter loopback path, giving the bench and on-chip self-check a decoded view of what the display would show.

---
 rtl/vga_sync_rx_pkg.sv | 31 +++
 rtl/vga_sync_rx_if.sv | 28 ++
 rtl/vga_sync_rx_sync_edge_meter.sv | 37 +++
 rtl/vga_sync_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_sync_rx_pkg.sv
// Shared constants and types for the VGA sync receiver (default 640x480@60 timing).
package vga_sync_rx_pkg;

  localparam int DATA_W  = 8;
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int POS_W   = 10;
  localparam int GOOD_W  = 4;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

endpackage

// File: rtl/vga_sync_rx_if.sv
// Incoming sync/pixel stream plus the decoded view produced by vga_sync_rx.
interface vga_sync_rx_if;
  import vga_sync_rx_pkg::*;

  logic               h_sync;
  logic               v_sync;
  logic [DATA_W-1:0]  data_in;
  logic [DATA_W-1:0]  data_out;
  logic [POS_W-1:0]   x;
  logic [POS_W-1:0]   y;
  logic               pixel_valid;
  logic               frame_start;
  logic               locked;
  logic               sync_err;
  logic [H_CNT_W-1:0] line_len;
  logic [V_CNT_W-1:0] frame_lines;

  modport master (
    output h_sync, v_sync, data_in,
    input  data_out, x, y, pixel_valid, frame_start, locked, sync_err, line_len, frame_lines
  );

  modport slave (
    input  h_sync, v_sync, data_in,
    output data_out, x, y, pixel_valid, frame_start, locked, sync_err, line_len, frame_lines
  );

endinterface

// File: rtl/vga_sync_rx_sync_edge_meter.sv
// Falling-edge detect on an active-low sync plus a saturating counter cleared by that edge.
// Counter updates on the sampling edge; period = cnt + inc is combinational; no backpressure.
module sync_edge_meter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync,
  input  logic         inc,
  output logic         fall,
  output logic [W-1:0] cnt,
  output logic [W-1:0] period
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic sync_q;

  // sync_q resets low so a sync already held low at reset release is not an edge.
  assign fall = sync_q & ~sync;

  always_comb begin
    period = cnt;
    if (inc && (cnt != CNT_MAX)) period = cnt + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= sync;
      cnt    <= fall ? '0 : period;
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers x/y, line/frame timing and lock from an h_sync/v_sync/pixel stream.
// data_in to data_out is two register stages with x/y aligned; streaming, no backpressure.
module vga_sync_rx
  import vga_sync_rx_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input logic          clk,
  input logic          rst,
  vga_sync_rx_if.slave bus
);

  localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;

  localparam logic [H_CNT_W-1:0] H_TOTAL_C = H_CNT_W'(H_TOTAL);
  localparam logic [H_CNT_W-1:0] H_ACT_LO  = H_CNT_W'(H_ACT_START);
  localparam logic [H_CNT_W-1:0] H_ACT_HI  = H_CNT_W'(H_ACT_START + H_VISIBLE - 1);
  localparam logic [V_CNT_W-1:0] V_TOTAL_C = V_CNT_W'(V_TOTAL);
  localparam logic [V_CNT_W-1:0] V_ACT_LO  = V_CNT_W'(V_ACT_START);
  localparam logic [V_CNT_W-1:0] V_ACT_HI  = V_CNT_W'(V_ACT_START + V_VISIBLE - 1);
  localparam logic [GOOD_W-1:0]  LOCK_LAST = GOOD_W'(LOCK_FRAMES - 1);

  logic               h_fall;
  logic               v_fall;
  logic [H_CNT_W-1:0] h_cnt;
  logic [H_CNT_W-1:0] h_period;
  logic [V_CNT_W-1:0] v_cnt;
  logic [V_CNT_W-1:0] v_lines;

  logic               h_seen;
  logic               frame_bad;
  logic [DATA_W-1:0]  data_q;
  state_t             state;
  logic [GOOD_W-1:0]  good_cnt;
  logic               err_q;

  logic               bad_line;
  logic               bad_frame;
  logic               visible;

  sync_edge_meter #(.W(H_CNT_W)) u_h_meter (
    .clk    (clk),
    .rst    (rst),
    .sync   (bus.h_sync),
    .inc    (1'b1),
    .fall   (h_fall),
    .cnt    (h_cnt),
    .period (h_period)
  );

  // Vertical meter counts H-edges; its own edge clears it, so a coincident V-edge wins.
  sync_edge_meter #(.W(V_CNT_W)) u_v_meter (
    .clk    (clk),
    .rst    (rst),
    .sync   (bus.v_sync),
    .inc    (h_fall),
    .fall   (v_fall),
    .cnt    (v_cnt),
    .period (v_lines)
  );

  assign bad_line  = h_fall & h_seen & (h_period != H_TOTAL_C);
  assign bad_frame = frame_bad | bad_line | (v_lines != V_TOTAL_C);
  assign visible   = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI) &&
                     (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_seen          <= 1'b0;
      frame_bad       <= 1'b0;
      data_q          <= '0;
      bus.line_len    <= '0;
      bus.frame_lines <= '0;
    end else begin
      data_q <= bus.data_in;
      if (h_fall) begin
        h_seen <= 1'b1;
        if (h_seen) bus.line_len <= h_period;
      end
      if (v_fall) begin
        bus.frame_lines <= v_lines;
        frame_bad       <= 1'b0;
      end else if (bad_line) begin
        frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (v_fall) begin
            state    <= ST_VERIFY;
            good_cnt <= '0;
          end
        end
        ST_VERIFY: begin
          if (v_fall) begin
            if (bad_frame) begin
              good_cnt <= '0;
            end else if (good_cnt == LOCK_LAST) begin
              state    <= ST_LOCKED;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          // A bad line drops lock at once rather than waiting for the frame to end.
          if (bad_line || (v_fall && bad_frame)) begin
            state <= ST_SEARCH;
            err_q <= 1'b1;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out    <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.pixel_valid <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.locked      <= 1'b0;
      bus.sync_err    <= 1'b0;
    end else begin
      bus.data_out    <= data_q;
      bus.x           <= POS_W'(h_cnt - H_ACT_LO);
      bus.y           <= POS_W'(v_cnt - V_ACT_LO);
      bus.pixel_valid <= (state == ST_LOCKED) && visible;
      bus.frame_start <= (state == ST_LOCKED) && visible &&
                         (h_cnt == H_ACT_LO) && (v_cnt == V_ACT_LO);
      bus.locked      <= (state == ST_LOCKED);
      bus.sync_err    <= err_q;
    end
  end

endmodule
